prime_streamer: RTL and testbench

//  Downstream controller for primogen: pulses go, waits for each result, buffers primes in a

---
 rtl/prime_streamer_pkg.sv | 17 +
 rtl/prime_streamer_if.sv | 12 +
 rtl/prime_streamer_fifo.sv | 49 ++++
 rtl/prime_streamer.sv | 86 ++++++++
 tb/tb_prime_streamer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prime_streamer_pkg.sv
// Shared types for the prime streamer: controller state encoding and default widths.
// No logic here; imported by the top and the bench.
package prime_streamer_pkg;

    localparam int W_DEF = 16;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_WAIT_RDY,
        S_IDLE,
        S_GO,
        S_WAIT_LOW,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/prime_streamer_if.sv
// Valid/ready stream carrying primes to the consumer.
// Master drives valid/data, slave drives ready; transfer on valid & ready.
interface prime_streamer_if #(
    parameter int W = 16
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/prime_streamer_fifo.sv
// Show-ahead sync FIFO; push visible at head the cycle after, pop on the clock edge.
// Push while full is ignored unless a pop frees the slot in the same cycle.
module prime_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign valid   = (level != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((level != FULL_LVL) || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Power-of-2 depth lets the pointers wrap by plain overflow.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/prime_streamer.sv
// Drives primogen one request at a time and streams captured primes out through a FIFO.
// Capture pushes in the WAIT_RDY cycle, m.valid next cycle; requests stall while the FIFO is full.
module prime_streamer
    import prime_streamer_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int DEPTH     = 4,
    parameter bit SKIP_ONE  = 1'b1,
    parameter int MAX_COUNT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    gen_go,
    input  logic                    gen_ready,
    input  logic                    gen_error,
    input  logic [W-1:0]            gen_res,
    prime_streamer_if.master        m,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        count,
    output logic                    busy,
    output logic                    err
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(MAX_COUNT);

    state_t         state_q;
    state_t         state_d;
    logic           capture;
    logic           push;
    logic           fifo_vld;
    logic [W-1:0]   fifo_dat;

    assign capture = (state_q == S_WAIT_RDY) && gen_ready;
    // primogen shows 1 straight out of reset; that is not a prime.
    assign push    = capture && !gen_error && !(SKIP_ONE && (gen_res == W'(1)));
    assign busy    = (state_q == S_GO) || (state_q == S_WAIT_LOW);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_RDY: if (gen_ready) state_d = gen_error ? S_ERR : S_IDLE;
            S_IDLE: begin
                if ((MAX_COUNT != 0) && (count == CNT_LIM)) state_d = S_DONE;
                else if (en && (level < FULL_LVL))          state_d = S_GO;
            end
            S_GO:       state_d = S_WAIT_LOW;
            S_WAIT_LOW: if (!gen_ready) state_d = S_WAIT_RDY;
            default:    state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT_RDY;
            gen_go  <= 1'b0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            gen_go  <= (state_d == S_GO);
            if (capture && gen_error) err <= 1'b1;
            if (push && (count != '1)) count <= count + 1'b1;
        end
    end

    prime_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (gen_res),
        .pop       (fifo_vld && m.ready),
        .head      (fifo_dat),
        .valid     (fifo_vld),
        .level     (level)
    );

    assign m.valid = fifo_vld;
    assign m.data  = fifo_dat;

endmodule

// File: tb/tb_prime_streamer.sv
// Bench for prime_streamer: behavioural primogen with random latency plus a prime-sequence scoreboard.
module tb_prime_streamer;
    import prime_streamer_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int MAXC  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          gen_go;
    logic          gen_ready = 1'b1;
    logic          gen_error = 1'b0;
    logic [W-1:0]  gen_res   = '0;
    logic [2:0]    level;
    logic [15:0]   count;
    logic          busy;
    logic          err;

    prime_streamer_if #(.W(W)) s_if ();

    prime_streamer #(
        .W         (W),
        .DEPTH     (DEPTH),
        .SKIP_ONE  (1'b1),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .gen_go    (gen_go),
        .gen_ready (gen_ready),
        .gen_error (gen_error),
        .gen_res   (gen_res),
        .m         (s_if),
        .level     (level),
        .count     (count),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int primes [64];
    int exp_idx = 0;
    int ngo = 0;
    int pidx = 0;
    int wc = 0;
    int err_after = 0;
    int ready_mode = 0;
    bit m_busy = 1'b0;
    bit prev_go = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Behavioural primogen: ready drops the cycle after go, stays low 1..4 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                gen_ready = 1'b1;
                gen_res   = 16'd1;
                gen_error = 1'b0;
                pidx      = 0;
                ngo       = 0;
                m_busy    = 1'b0;
            end else if (m_busy) begin
                if (wc > 1) wc--;
                else begin
                    gen_ready = 1'b1;
                    m_busy    = 1'b0;
                    if (err_after != 0 && ngo == err_after) gen_error = 1'b1;
                    else begin
                        gen_res = 16'(primes[pidx]);
                        pidx++;
                    end
                end
            end else if (prev_go) begin
                ngo++;
                gen_ready = 1'b0;
                m_busy    = 1'b1;
                wc        = $urandom_range(1, 4);
            end
        end
    end

    // Stream scoreboard and go-pulse monitor.
    always @(negedge clk) begin
        if (!rst) exp_idx = 0;
        else begin
            if (gen_go) begin
                chk("go_rdy", 32'(gen_ready), 32'd1);
                chk("go_pulse", 32'(prev_go), 32'd0);
            end
            if (s_if.valid && s_if.ready) begin
                chk("data", 32'(s_if.data), 32'(primes[exp_idx]));
                exp_idx++;
            end else if (!s_if.valid) begin
                chk("empty_data", 32'(s_if.data), 32'd0);
            end
            chk("lvl_le", 32'(level <= 3'(DEPTH)), 32'd1);
        end
        prev_go = gen_go;
    end

    task automatic tick();
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       s_if.ready = 1'b0;
            1:       s_if.ready = 1'b1;
            default: s_if.ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_reset(input int ea);
        rst = 1'b0;
        err_after = ea;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int n0;
        int k = 0;
        for (int v = 2; k < 64; v++)
            if (is_prime(v)) begin
                primes[k] = v;
                k++;
            end
        s_if.ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_go", 32'(gen_go), 0);
        chk("rst_valid", 32'(s_if.valid), 0);
        chk("rst_data", 32'(s_if.data), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_state", 32'(dut.state_q), 32'(S_WAIT_RDY));

        // Free-running stream with random consumer stalls
        rst = 1'b1;
        en = 1'b1;
        ready_mode = 2;
        for (int i = 0; i < 2000 && exp_idx < 12; i++) tick();
        chk("p1_got12", 32'(exp_idx), 32'd12);

        // Backpressure fills the FIFO then holds off requests
        ready_mode = 0;
        do_reset(0);
        repeat (60) tick();
        chk("p2_level", 32'(level), 32'd4);
        chk("p2_count", 32'(count), 32'd4);
        chk("p2_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("p2_head", 32'(s_if.data), 32'd2);
        repeat (20) tick();
        chk("p2_ngo", 32'(ngo), 32'd4);
        ready_mode = 1;
        for (int i = 0; i < 300 && exp_idx < 5; i++) tick();
        chk("p2_idx", 32'(exp_idx), 32'd5);

        // Generator error on the third request
        ready_mode = 0;
        do_reset(3);
        repeat (80) tick();
        chk("p3_err", 32'(err), 32'd1);
        chk("p3_state", 32'(dut.state_q), 32'(S_ERR));
        chk("p3_level", 32'(level), 32'd2);
        chk("p3_count", 32'(count), 32'd2);
        chk("p3_ngo", 32'(ngo), 32'd3);
        ready_mode = 1;
        repeat (20) tick();
        chk("p3_drained", 32'(exp_idx), 32'd2);
        chk("p3_valid", 32'(s_if.valid), 32'd0);
        chk("p3_ngo2", 32'(ngo), 32'd3);

        // Count limit
        ready_mode = 2;
        do_reset(0);
        for (int i = 0; i < 4000 && exp_idx < MAXC; i++) tick();
        repeat (40) tick();
        chk("p4_idx", 32'(exp_idx), 32'(MAXC));
        chk("p4_count", 32'(count), 32'(MAXC));
        chk("p4_state", 32'(dut.state_q), 32'(S_DONE));
        chk("p4_ngo", 32'(ngo), 32'(MAXC));
        chk("p4_busy", 32'(busy), 32'd0);

        // en dropped with a request in flight
        ready_mode = 1;
        en = 1'b1;
        do_reset(0);
        for (int i = 0; i < 100 && dut.state_q != S_WAIT_LOW; i++) tick();
        en = 1'b0;
        n0 = ngo;
        repeat (40) tick();
        chk("p5_ngo", 32'(ngo), 32'(n0));
        chk("p5_idx", 32'(exp_idx), 32'(n0));
        chk("p5_count", 32'(count), 32'(n0));
        chk("p5_state", 32'(dut.state_q), 32'(S_IDLE));
        en = 1'b1;
        for (int i = 0; i < 300 && exp_idx < n0 + 2; i++) tick();
        chk("p5_resume", 32'(exp_idx >= n0 + 2), 32'd1);

        // Reset asserted during WAIT_LOW
        do_reset(0);
        for (int i = 0; i < 300 && !(dut.state_q == S_WAIT_LOW && exp_idx >= 2); i++) tick();
        chk("p6_inflight", 32'(dut.state_q), 32'(S_WAIT_LOW));
        rst = 1'b0;
        #1;
        chk("p6_go", 32'(gen_go), 0);
        chk("p6_valid", 32'(s_if.valid), 0);
        chk("p6_level", 32'(level), 0);
        chk("p6_count", 32'(count), 0);
        chk("p6_busy", 32'(busy), 0);
        chk("p6_state", 32'(dut.state_q), 32'(S_WAIT_RDY));
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 300 && exp_idx < 4; i++) tick();
        chk("p6_restart", 32'(exp_idx), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
